// File: rtl/smvm_pkg.sv
// Shared SMVM types and constants: drain FSM state encoding and the frame header byte.
package smvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CSUM,
        FINISHED
    } drain_state_t;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

endpackage

// File: rtl/smvm_reg.sv
// Common register primitive: async active-low reset, synchronous clear and enable.
module smvm_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)     q <= '0;
        else if (clear) q <= '0;
        else if (en)    q <= d;
    end

endmodule

// File: rtl/accum_drain_tx.sv
// Streams the finished accumulator vector as a framed byte stream (header, LSB-first
// payload, XOR checksum) over a valid/ready link on the rising edge of done.
module accum_drain_tx #(
    parameter int unsigned MATRIX_SIZE = 128,
    parameter logic [7:0]  HEADER      = smvm_pkg::FRAME_HEADER
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic [MATRIX_SIZE-1:0][31:0] accum,
    input  logic                        done,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        sent
);
    import smvm_pkg::*;

    localparam int unsigned WW = $clog2(MATRIX_SIZE);
    localparam logic [WW-1:0] LAST_W = WW'(MATRIX_SIZE - 1);

    drain_state_t  state;
    logic [WW-1:0] word_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    csum;
    logic          done_q;
    logic          done_edge;
    logic          xfer;

    logic          last_byte;
    logic [1:0]    nxt_byte;
    logic [WW-1:0] nxt_word;
    logic [7:0]    nxt_val;
    logic [7:0]    csum_nxt;

    smvm_reg #(.W(1)) u_done_q (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (1'b1),
        .clear (1'b0),
        .d     (done),
        .q     (done_q)
    );

    assign done_edge = done & ~done_q;
    assign xfer      = tx_valid & tx_ready;

    // Byte offered after the current one is accepted; indices advance LSB byte first.
    always_comb begin
        last_byte = (byte_idx == 2'd3) && (word_idx == LAST_W);
        nxt_byte  = byte_idx + 2'd1;
        nxt_word  = (byte_idx == 2'd3) ? word_idx + WW'(1) : word_idx;
        nxt_val   = accum[nxt_word][{nxt_byte, 3'b000} +: 8];
        csum_nxt  = csum ^ tx_data;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            sent     <= 1'b0;
            word_idx <= '0;
            byte_idx <= '0;
            csum     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_edge) begin
                        state    <= smvm_pkg::HEADER;
                        tx_data  <= HEADER;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        csum     <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                smvm_pkg::HEADER: begin
                    if (xfer) begin
                        state   <= DATA;
                        tx_data <= accum[0][7:0];
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum_nxt;
                        if (last_byte) begin
                            state   <= CSUM;
                            tx_data <= csum_nxt;
                        end else begin
                            byte_idx <= nxt_byte;
                            word_idx <= nxt_word;
                            tx_data  <= nxt_val;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        state    <= FINISHED;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        sent     <= 1'b1;
                    end
                end
                FINISHED: begin
                    if (!done) begin
                        state <= IDLE;
                        sent  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_drain_tx.sv
// Directed bench for accum_drain_tx: expected frames built from the vectors by plain arithmetic.
module tb_accum_drain_tx;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    logic [1:0][31:0]   accum2;
    logic               done2, ready2, valid2, busy2, sent2;
    logic [7:0]         data2;
    logic [127:0][31:0] accum128;
    logic               done128, ready128, valid128, busy128, sent128;
    logic [7:0]         data128;

    accum_drain_tx #(.MATRIX_SIZE(2)) dut2 (
        .clk(clk), .rst_l(rst_l), .accum(accum2), .done(done2),
        .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
        .busy(busy2), .sent(sent2)
    );

    accum_drain_tx #(.MATRIX_SIZE(128)) dut128 (
        .clk(clk), .rst_l(rst_l), .accum(accum128), .done(done128),
        .tx_data(data128), .tx_valid(valid128), .tx_ready(ready128),
        .busy(busy128), .sent(sent128)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    logic [7:0] exp_q[2][$];
    logic [7:0] got_q[2][$];
    int         xfer_n[2];
    int         first_cyc[2];
    int         last_cyc[2];
    logic       hold_p[2];
    logic [7:0] hold_d[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame = header, every word's bytes LSB first, XOR of payload bytes.
    task automatic push_frame(input int id);
        logic [7:0] b, cs;
        int unsigned n;
        logic [31:0] w;
        n  = (id == 0) ? 2 : 128;
        cs = 8'h00;
        exp_q[id].push_back(8'hA5);
        for (int unsigned i = 0; i < n; i++) begin
            w = (id == 0) ? accum2[i] : accum128[i];
            for (int unsigned k = 0; k < 4; k++) begin
                b  = 8'(w >> (8 * k));
                cs = cs ^ b;
                exp_q[id].push_back(b);
            end
        end
        exp_q[id].push_back(cs);
    endtask

    task automatic clear_log(input int id);
        got_q[id].delete();
        xfer_n[id] = 0;
    endtask

    task automatic check_port(input int id, input logic v, input logic r,
                              input logic [7:0] d, input logic b);
        chk($sformatf("busy_eq_valid%0d", id), b, v);
        if (hold_p[id]) begin
            chk($sformatf("hold_valid%0d", id), v, 1'b1);
            chk($sformatf("hold_data%0d", id), d, hold_d[id]);
        end
        if (v && r) begin
            if (exp_q[id].size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_byte%0d: got %h want no transfer", id, d);
            end else begin
                chk($sformatf("byte%0d_%0d", id, xfer_n[id]), d, exp_q[id].pop_front());
            end
            got_q[id].push_back(d);
            if (xfer_n[id] == 0) first_cyc[id] = cyc;
            last_cyc[id] = cyc;
            xfer_n[id]++;
        end
        hold_p[id] = v && !r;
        hold_d[id] = d;
    endtask

    // Single compare process: inputs settle at posedge+1, so negedge values decide the next edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_l) begin
            hold_p[0] = 1'b0;
            hold_p[1] = 1'b0;
        end else begin
            check_port(0, valid2, ready2, data2, busy2);
            check_port(1, valid128, ready128, data128, busy128);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle2(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (exp_q[0].size() == 0 && !valid2) break;
        end
        if (i == budget) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL timeout_frame2: got %0d bytes left want 0", exp_q[0].size());
        end
    endtask

    task automatic wait_xfers2(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (xfer_n[0] >= n) break;
        end
        if (i == budget) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL timeout_xfers2: got %0d want %0d", xfer_n[0], n);
        end
    endtask

    task automatic start2();
        done2 = 1'b0;
        step();
        clear_log(0);
        push_frame(0);
        done2 = 1'b1;
    endtask

    logic [7:0] lit1[10];
    int i6;

    initial begin
        lit1 = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hBB};
        hold_p[0] = 1'b0; hold_p[1] = 1'b0;
        xfer_n[0] = 0; xfer_n[1] = 0;
        rst_l = 1'b0;
        done2 = 1'b0; ready2 = 1'b1;
        done128 = 1'b0; ready128 = 1'b0;
        accum2 = {32'h000000FF, 32'h11223344};
        for (int i = 0; i < 128; i++) accum128[i] = 32'(i);
        #1;
        chk("rst_valid", valid2, 1'b0);
        chk("rst_data", data2, 8'h00);
        chk("rst_busy", busy2, 1'b0);
        chk("rst_sent", sent2, 1'b0);
        step();
        step();
        rst_l = 1'b1;
        step();

        // 1: back-to-back frame, header visible one cycle after the edge
        clear_log(0);
        push_frame(0);
        done2 = 1'b1;
        step();
        chk("t1_hdr_valid", valid2, 1'b1);
        chk("t1_hdr_data", data2, 8'hA5);
        wait_idle2(40);
        chk("t1_sent", sent2, 1'b1);
        chk("t1_busy", busy2, 1'b0);
        chk("t1_count", got_q[0].size(), 10);
        for (int k = 0; k < 10 && k < got_q[0].size(); k++)
            chk($sformatf("t1_lit%0d", k), got_q[0][k], lit1[k]);
        chk("t1_no_bubble", last_cyc[0] - first_cyc[0], 9);

        // 4: done stays high, no second frame
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t4_no_restart", valid2, 1'b0);
        end
        chk("t4_sent_held", sent2, 1'b1);
        start2();
        wait_idle2(40);
        chk("t4_second_count", got_q[0].size(), 10);
        chk("t4_second_csum", got_q[0][got_q[0].size()-1], 8'hBB);

        // 2: stall while 0x22 is offered
        start2();
        for (int k = 0; k < 20; k++) begin
            step();
            if (valid2 && data2 == 8'h22) break;
        end
        ready2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_stall_valid", valid2, 1'b1);
            chk("t2_stall_data", data2, 8'h22);
        end
        ready2 = 1'b1;
        wait_idle2(40);
        chk("t2_count", got_q[0].size(), 10);
        chk("t2_csum", got_q[0][got_q[0].size()-1], 8'hBB);

        // 5: done falls mid-payload; sent pulses for one cycle
        start2();
        wait_xfers2(4, 40);
        done2 = 1'b0;
        wait_idle2(40);
        chk("t5_count", got_q[0].size(), 10);
        chk("t5_sent_pulse", sent2, 1'b1);
        step();
        chk("t5_sent_drop", sent2, 1'b0);

        // 3: reset while 6th byte offered, restart with done still high
        start2();
        wait_xfers2(5, 40);
        rst_l = 1'b0;
        #1;
        chk("t3_rst_valid", valid2, 1'b0);
        chk("t3_rst_busy", busy2, 1'b0);
        exp_q[0].delete();
        step();
        step();
        clear_log(0);
        push_frame(0);
        rst_l = 1'b1;
        step();
        chk("t3_restart_hdr", data2, 8'hA5);
        chk("t3_restart_valid", valid2, 1'b1);
        wait_idle2(40);
        chk("t3_count", got_q[0].size(), 10);

        // 6: 128-word frame with random ready
        clear_log(1);
        push_frame(1);
        done128 = 1'b1;
        for (i6 = 0; i6 < 4000; i6++) begin
            ready128 = 1'($urandom_range(0, 1));
            step();
            if (exp_q[1].size() == 0 && !valid128) break;
        end
        if (i6 == 4000) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL timeout_frame128: got %0d bytes want 514", xfer_n[1]);
        end
        chk("t6_count", xfer_n[1], 514);
        if (got_q[1].size() == 514) begin
            chk("t6_w1_b0", got_q[1][5], 8'h01);
            chk("t6_w127_b0", got_q[1][509], 8'h7F);
            chk("t6_csum", got_q[1][513], 8'h00);
        end
        chk("t6_sent", sent128, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
